vend_controller: RTL and testbench

VEND_CONTROLLER -- requirements
Module: vend_controller

---
 rtl/vend_pkg.sv | 13 +
 rtl/vend_change_unit.sv | 26 ++
 rtl/vend_controller.sv | 91 +++++++++
 tb/tb_vend_controller.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: shared state encoding, coin values and item prices for the vending controller.
package vend_pkg;
    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_DISPENSE, S_CHANGE, S_REFUND} state_t;
    localparam logic [5:0] COIN5_VAL  = 6'd5;
    localparam logic [5:0] COIN10_VAL = 6'd10;
    localparam logic [5:0] PRICE0 = 6'd15;
    localparam logic [5:0] PRICE1 = 6'd20;
    localparam logic [5:0] PRICE2 = 6'd25;
    localparam logic [5:0] PRICE3 = 6'd30;
    function automatic logic [5:0] price_of(input logic [1:0] item);
        return item == 2'd0 ? PRICE0 : item == 2'd1 ? PRICE1 : item == 2'd2 ? PRICE2 : PRICE3;
    endfunction
endpackage

// File: rtl/vend_change_unit.sv
// vend_change_unit: serialises an amount into back-to-back change5 pulses, done on the last one.
module vend_change_unit
    import vend_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [5:0] amount,
    output logic       change5,
    output logic       done
);
    logic [5:0] rem;
    always_ff @(posedge clock) begin
        if (reset) begin
            rem     <= 6'd0;
            change5 <= 1'b0;
        end else if (load) begin
            rem     <= amount - COIN5_VAL;
            change5 <= 1'b1;
        end else begin
            rem     <= rem != 6'd0 ? rem - COIN5_VAL : rem;
            change5 <= rem != 6'd0;
        end
    end
    assign done = change5 && rem == 6'd0;
endmodule

// File: rtl/vend_controller.sv
// vend_controller: four-item coin vending FSM with stock tracking and change/refund.
// Define VEND_TIMEOUT_EN to auto-refund after TIMEOUT_CYCLES coinless cycles in COLLECT.
module vend_controller
    import vend_pkg::*;
#(
    parameter logic [3:0] STOCK_INIT     = 4'd9,
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] sel,
    input  logic       coin5,
    input  logic       coin10,
    input  logic       cancel,
    input  logic       restock,
    output logic       dispense,
    output logic [1:0] item_out,
    output logic       change5,
    output logic       coin_reject,
    output logic       busy,
    output logic [5:0] credit,
    output logic [3:0] sold_out
);
    state_t     state, state_n;
    logic [3:0] stock   [4];
    logic [3:0] stock_n [4];
    logic       coin_any, accept, tmo, chg_load, chg_done;
    logic [5:0] coin_val, sum, remain, credit_n, price_n;
    logic [1:0] item_n;
    assign coin_any = coin5 | coin10;
`ifdef VEND_TIMEOUT_EN
    logic [7:0] tcnt;
    assign tmo = state == S_COLLECT && !coin_any && tcnt == TIMEOUT_CYCLES - 8'd1;
    always_ff @(posedge clock)
        tcnt <= (reset || state != S_COLLECT || coin_any || tmo) ? 8'd0 : tcnt + 8'd1;
`else
    assign tmo = 1'b0;
`endif
    // item_out doubles as the latched selection, so it is valid throughout DISPENSE
    always_comb begin
        coin_val = coin10 ? COIN10_VAL : COIN5_VAL;
        accept   = coin_any && !(coin5 && coin10) &&
                   ((state == S_IDLE && !sold_out[sel]) || (state == S_COLLECT && !cancel));
        item_n   = (state == S_IDLE && accept) ? sel : item_out;
        price_n  = price_of(item_n);
        sum      = (state == S_IDLE ? 6'd0 : credit) + coin_val;
        remain   = credit - price_of(item_out);
        case (state)
            S_IDLE, S_COLLECT: state_n = (state == S_COLLECT && (cancel || tmo)) ? S_REFUND :
                                         accept ? (sum >= price_n ? S_DISPENSE : S_COLLECT) : state;
            S_DISPENSE:        state_n = remain != 6'd0 ? S_CHANGE : S_IDLE;
            default:           state_n = chg_done ? S_IDLE : state;
        endcase
        credit_n = accept ? sum : state == S_DISPENSE ? remain :
                   (state == S_CHANGE || state == S_REFUND) ? credit - COIN5_VAL : credit;
        chg_load = (state == S_DISPENSE && remain != 6'd0) || (state == S_COLLECT && state_n == S_REFUND);
        for (int i = 0; i < 4; i++)
            stock_n[i] = restock ? STOCK_INIT :
                         (state == S_DISPENSE && item_out == 2'(i) && stock[i] != 4'd0) ? stock[i] - 4'd1 : stock[i];
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            credit      <= 6'd0;
            item_out    <= 2'd0;
            dispense    <= 1'b0;
            busy        <= 1'b0;
            coin_reject <= 1'b0;
            sold_out    <= 4'd0;
            stock       <= '{default: STOCK_INIT};
        end else begin
            state       <= state_n;
            credit      <= credit_n;
            item_out    <= item_n;
            dispense    <= state_n == S_DISPENSE;
            busy        <= state_n == S_DISPENSE || state_n == S_CHANGE || state_n == S_REFUND;
            coin_reject <= coin_any && !accept;
            stock       <= stock_n;
            for (int i = 0; i < 4; i++)
                sold_out[i] <= stock_n[i] == 4'd0;
        end
    end
    vend_change_unit u_change (
        .clock   (clock),
        .reset   (reset),
        .load    (chg_load),
        .amount  (state == S_DISPENSE ? remain : credit),
        .change5 (change5),
        .done    (chg_done)
    );
endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: transaction-level reference model feeding per-output scoreboard queues.
module tb_vend_controller;
    localparam int SI  = 2;
    localparam int TMO = 8;
    logic       clock = 0, reset = 1, coin5 = 0, coin10 = 0, cancel = 0, restock = 0;
    logic [1:0] sel = 0;
    logic       dispense, change5, coin_reject, busy;
    logic [1:0] item_out;
    logic [5:0] credit;
    logic [3:0] sold_out;
    vend_controller #(.STOCK_INIT(4'(SI)), .TIMEOUT_CYCLES(8'(TMO))) dut (
        .clock(clock), .reset(reset), .sel(sel), .coin5(coin5), .coin10(coin10),
        .cancel(cancel), .restock(restock), .dispense(dispense), .item_out(item_out),
        .change5(change5), .coin_reject(coin_reject), .busy(busy), .credit(credit),
        .sold_out(sold_out)
    );
    always #5 clock = ~clock;
    typedef struct {int cyc; int val;} ev_t;
    ev_t q_disp[$], q_chg[$], q_rej[$];
    int  checks = 0, errors = 0, cyc = 0;
    int  credit_m = 0, item_m = 0, busy_left = 0, tcnt_m = 0, dec_item = 0;
    bit  collecting = 0, pend_dec = 0;
    int  stock_m[4] = '{SI, SI, SI, SI};
    int  price[4] = '{15, 20, 25, 30};
    function automatic ev_t ev(input int c, input int v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        return e;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask
    task automatic refund();
        for (int j = 0; j < credit_m / 5; j++) q_chg.push_back(ev(cyc + j, credit_m - 5 * j));
        busy_left  = credit_m / 5;
        collecting = 0;
        credit_m   = 0;
    endtask
    // One clock edge of the vending rules, applied to the inputs seen at that edge
    task automatic step();
        bit coin, both, purchased;
        int v, rem;
        coin = coin5 | coin10;
        both = coin5 & coin10;
        v = coin10 ? 10 : 5;
        purchased = 0;
        if (busy_left > 0) begin
            if (coin) q_rej.push_back(ev(cyc, 0));
            busy_left--;
        end else if (!collecting) begin
            if (coin && (both || stock_m[sel] == 0)) q_rej.push_back(ev(cyc, 0));
            else if (coin) begin
                credit_m = v; item_m = sel; collecting = 1; tcnt_m = 0;
            end
        end else if (cancel) begin
            if (coin) q_rej.push_back(ev(cyc, 0));
            refund();
        end else if (!coin) begin
`ifdef VEND_TIMEOUT_EN
            tcnt_m++;
            if (tcnt_m == TMO) refund();
`endif
        end else begin
            tcnt_m = 0;
            if (both) q_rej.push_back(ev(cyc, 0));
            else begin
                credit_m += v;
                if (credit_m >= price[item_m]) begin
                    q_disp.push_back(ev(cyc, item_m));
                    rem = credit_m - price[item_m];
                    for (int j = 1; j <= rem / 5; j++) q_chg.push_back(ev(cyc + j, rem - 5 * (j - 1)));
                    busy_left  = 1 + rem / 5;
                    collecting = 0;
                    credit_m   = 0;
                    purchased  = 1;
                end
            end
        end
        if (restock) foreach (stock_m[i]) stock_m[i] = SI;
        else if (pend_dec && stock_m[dec_item] > 0) stock_m[dec_item]--;
        pend_dec = purchased;
        dec_item = item_m;
    endtask
    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            q_disp.delete(); q_chg.delete(); q_rej.delete();
            credit_m = 0; collecting = 0; busy_left = 0; tcnt_m = 0; pend_dec = 0;
            foreach (stock_m[i]) stock_m[i] = SI;
        end else step();
    end
    always @(negedge clock) begin
        bit e;
        logic [3:0] so_m;
        e = q_disp.size() > 0 && q_disp[0].cyc == cyc;
        chk("dispense", dispense, e);
        if (e) begin
            chk("item_out", item_out, q_disp[0].val);
            void'(q_disp.pop_front());
        end
        e = q_chg.size() > 0 && q_chg[0].cyc == cyc;
        chk("change5", change5, e);
        if (e) begin
            chk("change_credit", credit, q_chg[0].val);
            void'(q_chg.pop_front());
        end
        e = q_rej.size() > 0 && q_rej[0].cyc == cyc;
        chk("coin_reject", coin_reject, e);
        if (e) void'(q_rej.pop_front());
        chk("busy", busy, busy_left > 0);
        for (int i = 0; i < 4; i++) so_m[i] = stock_m[i] == 0;
        chk("sold_out", sold_out, so_m);
        if (busy_left == 0) chk("credit", credit, credit_m);
    end
    task automatic drv(input logic [1:0] s, input logic c5, input logic c10, input logic cn, input logic rs);
        @(negedge clock);
        sel = s; coin5 = c5; coin10 = c10; cancel = cn; restock = rs;
    endtask
    task automatic idle(input int n);
        repeat (n) drv(sel, 0, 0, 0, 0);
    endtask
    initial begin
        repeat (3) @(negedge clock);
        chk("reset_item_out", item_out, 0);
        chk("reset_credit", credit, 0);
        reset = 0;
        drv(0, 0, 1, 0, 0); drv(0, 0, 1, 0, 0); idle(5);
        drv(3, 1, 0, 0, 0); drv(3, 0, 1, 0, 0); drv(3, 0, 1, 0, 0); drv(3, 0, 1, 0, 0); idle(5);
        drv(2, 0, 1, 0, 0); drv(2, 0, 0, 1, 0); idle(5);
        drv(1, 1, 1, 0, 0); idle(2);
        drv(0, 0, 1, 0, 0); drv(0, 0, 1, 0, 0); drv(0, 1, 0, 0, 0); drv(0, 1, 0, 0, 0); idle(4);
        drv(1, 0, 0, 0, 1);
        drv(1, 0, 1, 0, 0); drv(1, 0, 1, 0, 0); idle(3);
        drv(1, 0, 1, 0, 0); drv(1, 0, 1, 0, 0); idle(3);
        drv(1, 1, 0, 0, 0); idle(1);
        chk("sold_out_item1", sold_out[1], 1);
        drv(1, 0, 0, 0, 1); idle(1);
        chk("restock_clears", sold_out, 0);
        drv(1, 1, 0, 0, 0); drv(1, 0, 0, 1, 0); idle(4);
        drv(3, 1, 0, 0, 0); idle(20); drv(3, 0, 0, 1, 0); idle(4);
        drv(0, 0, 1, 0, 0); drv(0, 0, 1, 0, 0); drv(0, 0, 0, 0, 0);
        reset = 1;
        idle(1);
        reset = 0;
        chk("midreset_credit", credit, 0);
        chk("midreset_change5", change5, 0);
        repeat (3000) @(negedge clock) begin
            coin5   = $urandom_range(0, 99) < 25;
            coin10  = $urandom_range(0, 99) < 25;
            cancel  = $urandom_range(0, 99) < 4;
            restock = $urandom_range(0, 99) < 2;
            sel     = 2'($urandom_range(0, 3));
        end
        idle(40);
        chk("drain", q_disp.size() + q_chg.size() + q_rej.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
